// File: rtl/step_ramp_gen_if.sv
// Command/status bundle for step_ramp_gen: move request inputs and the step strobe/status outputs.
interface step_ramp_gen_if #(
    parameter int PERIOD_W = 32
);
    logic                start;
    logic [15:0]         move_steps;
    logic [PERIOD_W-1:0] target_period;
    logic                stop;
    logic                pulse;
    logic                busy;
    logic                done;
    logic [PERIOD_W-1:0] cur_period;

    modport master (
        output start, move_steps, target_period, stop,
        input  pulse, busy, done, cur_period
    );

    modport slave (
        input  start, move_steps, target_period, stop,
        output pulse, busy, done, cur_period
    );
endinterface

// File: rtl/step_ramp_gen.sv
// Trapezoidal step-rate generator; first pulse cur_period cycles after start, no backpressure (pulse is a strobe).
// Define STEP_RAMP_STOP_EN to enable controlled stop; otherwise stop is ignored and every move runs to completion.
module step_ramp_gen #(
    parameter int PERIOD_W     = 32,
    parameter int START_PERIOD = 100,
    parameter int ACCEL_DEC    = 10,
    parameter int MIN_PERIOD   = 2
) (
    input  logic           clk,
    input  logic           resetb,
    step_ramp_gen_if.slave bus
);
    localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] DEC_P   = PERIOD_W'(ACCEL_DEC);
    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);

    typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cur_q, cur_d;
    logic [PERIOD_W-1:0] tgt_q, tgt_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [15:0]         rem_q, rem_d;
    logic [15:0]         ramp_q, ramp_d;

    logic                moving;
    logic                pulse_w;
    logic                stop_req;
    logic [15:0]         rem_after;
    logic [PERIOD_W-1:0] cur_up;
    logic [15:0]         ramp_dn;
    logic [PERIOD_W-1:0] tgt_in;

    assign moving  = state_q inside {S_ACCEL, S_CRUISE, S_DECEL};
    // cnt_q counts 1..cur_q within an interval; >= keeps a degenerate zero period from stalling
    assign pulse_w = moving && (cnt_q >= cur_q);
    assign cur_up  = ((cur_q >= START_P) || (START_P - cur_q <= DEC_P)) ? START_P : cur_q + DEC_P;
    assign ramp_dn = (ramp_q == 16'd0) ? 16'd0 : ramp_q - 16'd1;
    assign tgt_in  = (bus.target_period < MIN_P) ? MIN_P : bus.target_period;

`ifdef STEP_RAMP_STOP_EN
    assign stop_req = bus.stop && ((state_q == S_ACCEL) || (state_q == S_CRUISE));
`else
    // stop stays on the port but has no effect in this build
    assign stop_req = bus.stop & 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        ramp_d    = ramp_q;
        rem_after = rem_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    rem_d  = bus.move_steps;
                    cur_d  = START_P;
                    ramp_d = 16'd0;
                    cnt_d  = PERIOD_W'(1);
                    if (bus.move_steps == 16'd0) begin
                        state_d = S_DONE;
                    end else if (tgt_in >= START_P) begin
                        tgt_d   = START_P;
                        state_d = S_CRUISE;
                    end else begin
                        tgt_d   = tgt_in;
                        state_d = S_ACCEL;
                    end
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                cnt_d     = pulse_w ? PERIOD_W'(1) : cnt_q + PERIOD_W'(1);
                rem_after = pulse_w ? rem_q - 16'd1 : rem_q;
                if (stop_req && (ramp_q < rem_after)) begin
                    rem_after = ramp_q;
                end
                rem_d = rem_after;
                if (rem_after == 16'd0) begin
                    state_d = S_DONE;
                end else if (pulse_w && (stop_req || (rem_after <= ramp_q) || (state_q == S_DECEL))) begin
                    // the pulse that enters DECEL already lengthens the next interval
                    cur_d   = cur_up;
                    ramp_d  = ramp_dn;
                    state_d = S_DECEL;
                end else if (stop_req) begin
                    state_d = S_DECEL;
                end else if (pulse_w && (state_q == S_ACCEL)) begin
                    ramp_d = ramp_q + 16'd1;
                    if (cur_q - tgt_q <= DEC_P) begin
                        cur_d   = tgt_q;
                        state_d = S_CRUISE;
                    end else begin
                        cur_d = cur_q - DEC_P;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            state_q <= S_IDLE;
            cur_q   <= START_P;
            tgt_q   <= START_P;
            cnt_q   <= '0;
            rem_q   <= 16'd0;
            ramp_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ramp_q  <= ramp_d;
        end
    end

    assign bus.pulse      = pulse_w;
    assign bus.busy       = moving;
    assign bus.done       = (state_q == S_DONE);
    assign bus.cur_period = cur_q;
endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen: table of moves with hand-computed interval profiles plus reset/stop sequences.
module tb_step_ramp_gen;
    logic clk = 1'b0;
    logic resetb;

    step_ramp_gen_if #(.PERIOD_W(32)) bus ();

    step_ramp_gen #(
        .PERIOD_W    (32),
        .START_PERIOD(100),
        .ACCEL_DEC   (10),
        .MIN_PERIOD  (2)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    steps;
        int    tgt;
        int    hold;
        int    stop_at;
        int    off;
        int    n;
        int    min_cur;
    } vec_t;

    vec_t vecs[8];
    int   exp_q[$];
    int   got[0:63];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_rep(input int v, input int r);
        for (int i = 0; i < r; i++) exp_q.push_back(v);
    endfunction

    function automatic void set_vec(input int idx, input string name, input int steps, input int tgt,
                                    input int hold, input int stop_at, input int off, input int min_cur);
        vecs[idx].name    = name;
        vecs[idx].steps   = steps;
        vecs[idx].tgt     = tgt;
        vecs[idx].hold    = hold;
        vecs[idx].stop_at = stop_at;
        vecs[idx].off     = off;
        vecs[idx].n       = exp_q.size() - off;
        vecs[idx].min_cur = min_cur;
    endfunction

    // Called at a negedge; start is sampled at the following rising edge.
    task automatic run_vec(input vec_t v);
        int k, last_k, n, done_k, min_cur, busy_err, idle_err;
        bit finished;
        k = 0; last_k = 0; n = 0; done_k = 0; min_cur = 100; busy_err = 0; idle_err = 0; finished = 0;
        bus.start         = 1'b1;
        bus.move_steps    = 16'(v.steps);
        bus.target_period = 32'(v.tgt);
        bus.stop          = 1'b0;
        while (!finished && k < 3000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.move_steps    = 16'd77;
                bus.target_period = 32'd3;
            end
            if (k > v.hold) bus.start = 1'b0;
            bus.stop = 1'b0;
            if (bus.busy != (n < v.n)) busy_err++;
            if (bus.busy && (bus.cur_period < 32'(min_cur))) min_cur = int'(bus.cur_period);
            if (bus.pulse) begin
                if (n < 64) got[n] = k - last_k;
                n++;
                last_k = k;
                if (n == v.stop_at) bus.stop = 1'b1;
                if (bus.done) busy_err++;
            end
            if (bus.done) begin
                done_k   = k;
                finished = 1'b1;
            end
        end
        check({v.name, " finished"}, finished, 1);
        check({v.name, " pulses"}, n, v.n);
        for (int i = 0; i < n && i < v.n; i++)
            check($sformatf("%s int%0d", v.name, i), got[i], exp_q[v.off + i]);
        check({v.name, " done_gap"}, done_k - last_k, 1);
        check({v.name, " busy_err"}, busy_err, 0);
        check({v.name, " min_cur"}, min_cur, v.min_cur);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            k++;
            if (k > v.hold) bus.start = 1'b0;
            if (bus.pulse || bus.done || bus.busy) idle_err++;
        end
        check({v.name, " post_idle"}, idle_err, 0);
        bus.start = 1'b0;
    endtask

    initial begin
        int off, n, k, reset_err;
        resetb            = 1'b1;
        bus.start         = 1'b0;
        bus.move_steps    = 16'd0;
        bus.target_period = 32'd0;
        bus.stop          = 1'b0;

        off = exp_q.size();
        for (int p = 100; p >= 60; p -= 10) exp_q.push_back(p);
        push_rep(50, 10);
        for (int p = 60; p <= 100; p += 10) exp_q.push_back(p);
        set_vec(0, "prof20", 20, 50, 10, 0, off, 50);

        off = exp_q.size();
        exp_q.push_back(100); exp_q.push_back(90); exp_q.push_back(80);
        exp_q.push_back(70);  exp_q.push_back(80); exp_q.push_back(90);
        set_vec(1, "short6", 6, 50, 10, 0, off, 70);

        off = exp_q.size();
        set_vec(2, "zero", 0, 50, 1, 0, off, 100);

        off = exp_q.size();
        push_rep(100, 3);
        set_vec(3, "slow_tgt", 3, 200, 10, 0, off, 100);

        off = exp_q.size();
        exp_q.push_back(100); exp_q.push_back(90); exp_q.push_back(80); exp_q.push_back(90);
        set_vec(4, "min_clamp", 4, 1, 10, 0, off, 80);

        off = exp_q.size();
        exp_q.push_back(100);
        set_vec(5, "one", 1, 50, 10, 0, off, 100);

        off = exp_q.size();
        exp_q.push_back(100);
        push_rep(95, 10);
        exp_q.push_back(100);
        set_vec(6, "sat95", 12, 95, 10, 0, off, 95);

        off = exp_q.size();
        for (int p = 100; p >= 60; p -= 10) exp_q.push_back(p);
`ifdef STEP_RAMP_STOP_EN
        push_rep(50, 3);
`else
        push_rep(50, 10);
`endif
        for (int p = 60; p <= 100; p += 10) exp_q.push_back(p);
        set_vec(7, "stop8", 20, 50, 10, 8, off, 50);

        // reset state, with start asserted to show it is ignored under reset
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.move_steps = 16'd5;
        @(negedge clk);
        check("rst pulse", bus.pulse, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst cur_period", bus.cur_period, 100);
        bus.start = 1'b0;
        @(negedge clk);
        resetb = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // reset mid-move after the fourth pulse
        bus.start         = 1'b1;
        bus.move_steps    = 16'd20;
        bus.target_period = 32'd50;
        n = 0; k = 0;
        while (n < 4 && k < 1000) begin
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            if (bus.pulse) n++;
        end
        check("abort reached pulse4", n, 4);
        resetb = 1'b1;
        #1;
        check("abort pulse", bus.pulse, 0);
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort cur_period", bus.cur_period, 100);
        reset_err = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.pulse || bus.busy || bus.done) reset_err++;
        end
        check("abort held", reset_err, 0);
        resetb = 1'b0;
        run_vec(vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
